// File: rtl/clk_div_multi.sv
// Multi-channel clock/tick divider: per-channel runtime divisor with shadow/active
// double buffering, per-channel enable and a global phase restart.
module clk_div_multi #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = CLK_FREQ_HZ / 2 - 1,
    parameter int unsigned SEL_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              restart,
    input  logic              div_we,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [DIV_W-1:0]  div_data,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [DIV_W-1:0]  act_q [NUM_CH];
    logic [DIV_W-1:0]  act_d [NUM_CH];
    logic [DIV_W-1:0]  shd_q [NUM_CH];
    logic [DIV_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wr_hit;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // Out-of-range selects never match any channel, so they are dropped here.
            wr_hit[i] = div_we && (32'(div_sel) == i);
            shd_d[i]  = wr_hit[i] ? div_data : shd_q[i];

            cnt_d[i]  = cnt_q[i];
            // Active divisor follows the post-write shadow unless mid-period.
            act_d[i]  = shd_d[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = 1'b0;

            if (restart) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (ch_en[i]) begin
                if (cnt_q[i] == act_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    clk_d[i]  = ~clk_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                    act_d[i] = act_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= RST_DIV;
                shd_q[i] <= RST_DIV;
            end
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: period-level reference model compared every
// cycle, plus hand-computed tick/clk_out expectations at fixed cycles.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int DW  = 26;
    localparam int SW  = 3;
    localparam int DEF = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] ch_en = '1;
    logic           restart = 1'b0;
    logic           div_we = 1'b0;
    logic [SW-1:0]  div_sel = '0;
    logic [DW-1:0]  div_data = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(
        .CLK_FREQ_HZ (50_000_000),
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEF),
        .SEL_W       (SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ch_en    (ch_en),
        .restart  (restart),
        .div_we   (div_we),
        .div_sel  (div_sel),
        .div_data (div_data),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Reference model: each channel owes `period` enabled cycles before its next tick.
    int unsigned    pending_div [NCH];
    int unsigned    period      [NCH];
    int unsigned    elapsed     [NCH];
    logic [NCH-1:0] exp_tick = '0;
    logic [NCH-1:0] exp_clk  = '0;
    bit             model_valid = 1'b0;
    int             cyc = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                pending_div[i] = DEF;
                period[i]      = DEF + 1;
                elapsed[i]     = 0;
            end
            exp_tick    = '0;
            exp_clk     = '0;
            cyc         = 0;
            model_valid = 1'b1;
        end else begin
            cyc = restart ? 0 : cyc + 1;
            for (int i = 0; i < NCH; i++) begin
                if (div_we && int'(div_sel) == i)
                    pending_div[i] = int'(div_data);
                exp_tick[i] = 1'b0;
                if (restart) begin
                    elapsed[i] = 0;
                    exp_clk[i] = 1'b0;
                    period[i]  = pending_div[i] + 1;
                end else if (ch_en[i]) begin
                    elapsed[i] = elapsed[i] + 1;
                    if (elapsed[i] == period[i]) begin
                        exp_tick[i] = 1'b1;
                        exp_clk[i]  = ~exp_clk[i];
                        elapsed[i]  = 0;
                        period[i]   = pending_div[i] + 1;
                    end
                end else begin
                    period[i] = pending_div[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL model_tick cyc=%0d: got %b expected %b", cyc, tick, exp_tick);
            end
            checks++;
            if (clk_out !== exp_clk) begin
                errors++;
                $display("FAIL model_clk_out cyc=%0d: got %b expected %b", cyc, clk_out, exp_clk);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached %0d, required %0d", cyc, n);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic write_div(input logic [SW-1:0] sel, input logic [DW-1:0] data);
        div_we   = 1'b1;
        div_sel  = sel;
        div_data = data;
        step();
        div_we   = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and default divisor 4 on all channels
        repeat (3) step();
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_clk", 32'(clk_out), 32'h0);
        reset = 1'b0;
        wait_cyc(5);  chk("def_tick5", 32'(tick), 32'hF);  chk("def_clk5", 32'(clk_out), 32'hF);
        wait_cyc(6);  chk("def_tick6", 32'(tick), 32'h0);  chk("def_clk6", 32'(clk_out), 32'hF);
        wait_cyc(10); chk("def_tick10", 32'(tick), 32'hF); chk("def_clk10", 32'(clk_out), 32'h0);
        wait_cyc(15); chk("def_tick15", 32'(tick), 32'hF); chk("def_clk15", 32'(clk_out), 32'hF);

        // Channel 1 at D=9 (loaded through restart), then shortened to D=2 at cnt=3
        restart  = 1'b1;
        div_we   = 1'b1;
        div_sel  = 3'd1;
        div_data = 26'd9;
        step();
        restart  = 1'b0;
        div_we   = 1'b0;
        wait_cyc(3);
        write_div(3'd1, 26'd2);
        wait_cyc(9);  chk("ch1_tick9", 32'(tick[1]), 32'h0);
        wait_cyc(10); chk("ch1_tick10", 32'(tick[1]), 32'h1); chk("ch1_clk10", 32'(clk_out[1]), 32'h1);
        wait_cyc(11); chk("ch1_tick11", 32'(tick[1]), 32'h0);
        wait_cyc(13); chk("ch1_tick13", 32'(tick[1]), 32'h1); chk("ch1_clk13", 32'(clk_out[1]), 32'h0);
        wait_cyc(16); chk("ch1_tick16", 32'(tick[1]), 32'h1); chk("ch1_clk16", 32'(clk_out[1]), 32'h1);

        // Channel 2 to D=0: continuous tick after its terminal count at cycle 20
        wait_cyc(17);
        write_div(3'd2, 26'd0);
        wait_cyc(19); chk("ch2_tick19", 32'(tick[2]), 32'h0);
        wait_cyc(22); chk("ch2_tick22", 32'(tick[2]), 32'h1); chk("ch2_clk22", 32'(clk_out[2]), 32'h0);
        wait_cyc(23); chk("ch2_tick23", 32'(tick[2]), 32'h1); chk("ch2_clk23", 32'(clk_out[2]), 32'h1);
        wait_cyc(24); chk("ch2_tick24", 32'(tick[2]), 32'h1); chk("ch2_clk24", 32'(clk_out[2]), 32'h0);

        // Channel 0 paused at cnt=2 for 7 cycles
        do_restart();
        wait_cyc(2);
        ch_en[0] = 1'b0;
        wait_cyc(5);  chk("ch0_gap_tick5", 32'(tick[0]), 32'h0);
        wait_cyc(8);  chk("ch0_gap_clk8", 32'(clk_out[0]), 32'h0);
        wait_cyc(9);
        ch_en[0] = 1'b1;
        wait_cyc(11); chk("ch0_tick11", 32'(tick[0]), 32'h0);
        wait_cyc(12); chk("ch0_tick12", 32'(tick[0]), 32'h1); chk("ch0_clk12", 32'(clk_out[0]), 32'h1);

        // D = 3,5,7,11 then restart
        write_div(3'd0, 26'd3);
        write_div(3'd1, 26'd5);
        write_div(3'd2, 26'd7);
        write_div(3'd3, 26'd11);
        step();
        do_restart();
        chk("rst_clk0", 32'(clk_out), 32'h0);
        chk("rst_tick0", 32'(tick), 32'h0);
        wait_cyc(4);  chk("mix_tick4", 32'(tick), 32'h1);
        wait_cyc(6);  chk("mix_tick6", 32'(tick), 32'h2);
        wait_cyc(8);  chk("mix_tick8", 32'(tick), 32'h5);
        wait_cyc(12); chk("mix_tick12", 32'(tick), 32'hB);

        // Write to non-existent channel 4 is dropped
        write_div(3'd4, 26'd1);
        do_restart();
        wait_cyc(2);  chk("oor_tick2", 32'(tick), 32'h0);
        wait_cyc(4);  chk("oor_tick4", 32'(tick), 32'h1);
        wait_cyc(6);  chk("oor_tick6", 32'(tick), 32'h2);
        wait_cyc(20);

        // Reset during a write restores DEFAULT_DIV everywhere
        reset    = 1'b1;
        div_we   = 1'b1;
        div_sel  = 3'd0;
        div_data = 26'd1;
        step();
        div_we   = 1'b0;
        step();
        chk("rst2_tick", 32'(tick), 32'h0);
        chk("rst2_clk", 32'(clk_out), 32'h0);
        reset = 1'b0;
        wait_cyc(2);  chk("rst2_tick2", 32'(tick), 32'h0);
        wait_cyc(5);  chk("rst2_tick5", 32'(tick), 32'hF);  chk("rst2_clk5", 32'(clk_out), 32'hF);
        wait_cyc(10); chk("rst2_tick10", 32'(tick), 32'hF); chk("rst2_clk10", 32'(clk_out), 32'h0);
        wait_cyc(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
